ysyx_25010008_wb_arbiter: RTL and testbench

Write-back arbiter and scoreboard for the RV32E register file (16 GPRs plus mstatus/mtvec/mepc/mcause). It shares the file's single GPR write port and two CSR write ports between the ALU/CSR result path and the LSU load path. It registers the winning result onto the register file's write-back inputs and tracks pending destination writes so the issue stage stalls on RAW/WAW hazards and CSR ordering. It sits between EXU/LSU and the register file; its iss_* handshake gates the IDU→EXU issue.

---
 rtl/ysyx_25010008_wb_arbiter.sv | 149 ++++++++++++++
 tb/tb_ysyx_25010008_wb_arbiter.sv | 322 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ysyx_25010008_wb_arbiter.sv
// Write-back arbiter and issue scoreboard for the RV32E register file.
// Shares the GPR/CSR write ports between ALU and LSU and gates issue on hazards.
module ysyx_25010008_wb_arbiter #(
  parameter int MAX_OUT = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        iss_valid,
  output logic        iss_ready,
  input  logic [4:0]  iss_rs1,
  input  logic [4:0]  iss_rs2,
  input  logic [4:0]  iss_rd,
  input  logic        iss_rd_wen,
  input  logic        iss_csr_ren,
  input  logic        iss_csr_wen,
  input  logic        alu_valid,
  output logic        alu_ready,
  input  logic [4:0]  alu_rd,
  input  logic        alu_wen,
  input  logic [31:0] alu_wdata,
  input  logic        alu_csr_wen1,
  input  logic        alu_csr_wen2,
  input  logic [11:0] alu_csr_d1,
  input  logic [11:0] alu_csr_d2,
  input  logic [31:0] alu_csr_wdata1,
  input  logic [31:0] alu_csr_wdata2,
  input  logic        lsu_valid,
  output logic        lsu_ready,
  input  logic [4:0]  lsu_rd,
  input  logic        lsu_wen,
  input  logic [31:0] lsu_wdata,
  output logic        write_back,
  output logic        wen,
  output logic [4:0]  rd,
  output logic [31:0] wdata,
  output logic        csr_wen1,
  output logic        csr_wen2,
  output logic [11:0] csr_d1,
  output logic [11:0] csr_d2,
  output logic [31:0] csr_wdata1,
  output logic [31:0] csr_wdata2
);

  logic [15:0] pending;
  logic        csr_busy;
  logic [2:0]  outstanding;
  logic        last_grant;
  logic        grant_alu;
  logic        grant_lsu;
  logic        stall;
  logic        issue;
  logic        retire;
  logic [15:0] set_mask;
  logic [15:0] clr_mask;
  logic        unused_bits;

  assign unused_bits = ^{iss_rs1[4], iss_rs2[4], iss_rd[4]};

  // On a tie the requester not served last wins; last_grant=0 means ALU.
  assign grant_lsu = !reset && lsu_valid && (!alu_valid || !last_grant);
  assign grant_alu = !reset && alu_valid && (!lsu_valid || last_grant);
  assign alu_ready = grant_alu;
  assign lsu_ready = grant_lsu;

  assign stall = reset
    | pending[iss_rs1[3:0]]
    | pending[iss_rs2[3:0]]
    | (iss_rd_wen & pending[iss_rd[3:0]])
    | ((iss_csr_ren | iss_csr_wen) & csr_busy)
    | (outstanding == 3'(MAX_OUT));

  assign iss_ready = iss_valid & ~stall;
  assign issue     = iss_ready;
  assign retire    = write_back;

  always_comb begin
    set_mask = '0;
    clr_mask = '0;
    if (issue && iss_rd_wen) set_mask[iss_rd[3:0]] = 1'b1;
    if (retire && wen)       clr_mask[rd[3:0]] = 1'b1;
    set_mask[0] = 1'b0;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      pending     <= '0;
      csr_busy    <= 1'b0;
      outstanding <= '0;
      last_grant  <= 1'b0;
    end else begin
      // Set is applied after clear so a same-edge collision stays pending.
      pending <= (pending & ~clr_mask) | set_mask;
      if (issue && iss_csr_wen)
        csr_busy <= 1'b1;
      else if (retire && (csr_wen1 || csr_wen2))
        csr_busy <= 1'b0;
      case ({issue, retire})
        2'b10:   outstanding <= outstanding + 3'd1;
        2'b01:   outstanding <= outstanding - 3'd1;
        default: outstanding <= outstanding;
      endcase
      if (grant_alu)      last_grant <= 1'b0;
      else if (grant_lsu) last_grant <= 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      write_back <= 1'b0;
      wen        <= 1'b0;
      rd         <= '0;
      wdata      <= '0;
      csr_wen1   <= 1'b0;
      csr_wen2   <= 1'b0;
      csr_d1     <= '0;
      csr_d2     <= '0;
      csr_wdata1 <= '0;
      csr_wdata2 <= '0;
    end else if (grant_alu) begin
      write_back <= 1'b1;
      wen        <= alu_wen;
      rd         <= alu_rd;
      wdata      <= alu_wdata;
      csr_wen1   <= alu_csr_wen1;
      csr_wen2   <= alu_csr_wen2;
      csr_d1     <= alu_csr_d1;
      csr_d2     <= alu_csr_d2;
      csr_wdata1 <= alu_csr_wdata1;
      csr_wdata2 <= alu_csr_wdata2;
    end else if (grant_lsu) begin
      write_back <= 1'b1;
      wen        <= lsu_wen;
      rd         <= lsu_rd;
      wdata      <= lsu_wdata;
      csr_wen1   <= 1'b0;
      csr_wen2   <= 1'b0;
      csr_d1     <= '0;
      csr_d2     <= '0;
      csr_wdata1 <= '0;
      csr_wdata2 <= '0;
    end else begin
      write_back <= 1'b0;
      wen        <= 1'b0;
      csr_wen1   <= 1'b0;
      csr_wen2   <= 1'b0;
    end
  end

endmodule

// File: tb/tb_ysyx_25010008_wb_arbiter.sv
// Directed bench for the write-back arbiter: per-cycle vector table
// plus a hand-written outstanding-limit sequence.
module tb_ysyx_25010008_wb_arbiter;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        iss_valid = 1'b0;
  logic        iss_ready;
  logic [4:0]  iss_rs1 = '0;
  logic [4:0]  iss_rs2 = '0;
  logic [4:0]  iss_rd = '0;
  logic        iss_rd_wen = 1'b0;
  logic        iss_csr_ren = 1'b0;
  logic        iss_csr_wen = 1'b0;
  logic        alu_valid = 1'b0;
  logic        alu_ready;
  logic [4:0]  alu_rd = '0;
  logic        alu_wen = 1'b0;
  logic [31:0] alu_wdata = '0;
  logic        alu_csr_wen1 = 1'b0;
  logic        alu_csr_wen2 = 1'b0;
  logic [11:0] alu_csr_d1 = '0;
  logic [11:0] alu_csr_d2 = '0;
  logic [31:0] alu_csr_wdata1 = '0;
  logic [31:0] alu_csr_wdata2 = '0;
  logic        lsu_valid = 1'b0;
  logic        lsu_ready;
  logic [4:0]  lsu_rd = '0;
  logic        lsu_wen = 1'b0;
  logic [31:0] lsu_wdata = '0;
  logic        write_back;
  logic        wen;
  logic [4:0]  rd;
  logic [31:0] wdata;
  logic        csr_wen1;
  logic        csr_wen2;
  logic [11:0] csr_d1;
  logic [11:0] csr_d2;
  logic [31:0] csr_wdata1;
  logic [31:0] csr_wdata2;

  always #5 clock = ~clock;

  ysyx_25010008_wb_arbiter #(.MAX_OUT(4)) dut (
    .clock(clock), .reset(reset),
    .iss_valid(iss_valid), .iss_ready(iss_ready),
    .iss_rs1(iss_rs1), .iss_rs2(iss_rs2), .iss_rd(iss_rd),
    .iss_rd_wen(iss_rd_wen),
    .iss_csr_ren(iss_csr_ren), .iss_csr_wen(iss_csr_wen),
    .alu_valid(alu_valid), .alu_ready(alu_ready),
    .alu_rd(alu_rd), .alu_wen(alu_wen), .alu_wdata(alu_wdata),
    .alu_csr_wen1(alu_csr_wen1), .alu_csr_wen2(alu_csr_wen2),
    .alu_csr_d1(alu_csr_d1), .alu_csr_d2(alu_csr_d2),
    .alu_csr_wdata1(alu_csr_wdata1), .alu_csr_wdata2(alu_csr_wdata2),
    .lsu_valid(lsu_valid), .lsu_ready(lsu_ready),
    .lsu_rd(lsu_rd), .lsu_wen(lsu_wen), .lsu_wdata(lsu_wdata),
    .write_back(write_back), .wen(wen), .rd(rd), .wdata(wdata),
    .csr_wen1(csr_wen1), .csr_wen2(csr_wen2),
    .csr_d1(csr_d1), .csr_d2(csr_d2),
    .csr_wdata1(csr_wdata1), .csr_wdata2(csr_wdata2)
  );

  typedef struct packed {
    logic        rst;
    logic        iv;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  ird;
    logic        rdw;
    logic        cr;
    logic        cw;
    logic        av;
    logic [4:0]  ard;
    logic        aw;
    logic [31:0] awd;
    logic        ac1;
    logic [11:0] acd;
    logic [31:0] acwd;
    logic        lv;
    logic [4:0]  lrd;
    logic        lw;
    logic [31:0] lwd;
    logic        e_ir;
    logic        e_ar;
    logic        e_lr;
    logic        e_wb;
    logic        e_wen;
    logic [4:0]  e_rd;
    logic [31:0] e_wd;
    logic        e_c1;
    logic [11:0] e_cd;
    logic [31:0] e_cwd;
  } vec_t;

  vec_t tbl[$];
  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(string nm, int idx,
                     logic [31:0] got, logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s @%0d: got %h want %h", nm, idx, got, exp);
    end
  endtask

  function automatic vec_t z(logic rst);
    vec_t v;
    v = '0;
    v.rst = rst;
    return v;
  endfunction

  function automatic vec_t f_iss(vec_t v, logic [4:0] rs1,
      logic [4:0] rs2, logic [4:0] ird, logic rdw,
      logic cr, logic cw);
    v.iv = 1'b1; v.rs1 = rs1; v.rs2 = rs2; v.ird = ird;
    v.rdw = rdw; v.cr = cr; v.cw = cw;
    return v;
  endfunction

  function automatic vec_t f_alu(vec_t v, logic [4:0] ard,
      logic aw, logic [31:0] awd, logic ac1,
      logic [11:0] acd, logic [31:0] acwd);
    v.av = 1'b1; v.ard = ard; v.aw = aw; v.awd = awd;
    v.ac1 = ac1; v.acd = acd; v.acwd = acwd;
    return v;
  endfunction

  function automatic vec_t f_lsu(vec_t v, logic [4:0] lrd,
      logic lw, logic [31:0] lwd);
    v.lv = 1'b1; v.lrd = lrd; v.lw = lw; v.lwd = lwd;
    return v;
  endfunction

  function automatic vec_t f_exp(vec_t v, logic ir, logic ar,
      logic lr, logic wb, logic w, logic [4:0] r,
      logic [31:0] wd);
    v.e_ir = ir; v.e_ar = ar; v.e_lr = lr; v.e_wb = wb;
    v.e_wen = w; v.e_rd = r; v.e_wd = wd;
    return v;
  endfunction

  function automatic vec_t f_csr(vec_t v, logic c1,
      logic [11:0] cd, logic [31:0] cwd);
    v.e_c1 = c1; v.e_cd = cd; v.e_cwd = cwd;
    return v;
  endfunction

  task automatic drv(vec_t v);
    reset          = v.rst;
    iss_valid      = v.iv;
    iss_rs1        = v.rs1;
    iss_rs2        = v.rs2;
    iss_rd         = v.ird;
    iss_rd_wen     = v.rdw;
    iss_csr_ren    = v.cr;
    iss_csr_wen    = v.cw;
    alu_valid      = v.av;
    alu_rd         = v.ard;
    alu_wen        = v.aw;
    alu_wdata      = v.awd;
    alu_csr_wen1   = v.ac1;
    alu_csr_d1     = v.acd;
    alu_csr_wdata1 = v.acwd;
    lsu_valid      = v.lv;
    lsu_rd         = v.lrd;
    lsu_wen        = v.lw;
    lsu_wdata      = v.lwd;
  endtask

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  initial begin
    vec_t v;
    // 0: reset holds all readies low
    v = f_lsu(f_alu(f_iss(z(1), 0, 0, 5, 1, 0, 0),
          9, 1, 32'hdead, 0, 0, 0), 1, 1, 32'h1);
    tbl.push_back(f_exp(v, 0, 0, 0, 0, 0, 0, 0));
    // 1: issue rd=5
    v = f_iss(z(0), 0, 0, 5, 1, 0, 0);
    tbl.push_back(f_exp(v, 1, 0, 0, 0, 0, 0, 0));
    // 2: rs1=5 stalls; ALU returns rd=5
    v = f_alu(f_iss(z(0), 5, 0, 0, 0, 0, 0),
          5, 1, 32'h1234, 0, 0, 0);
    tbl.push_back(f_exp(v, 0, 1, 0, 0, 0, 0, 0));
    // 3: write_back cycle; rs2=5 still stalls
    v = f_iss(z(0), 0, 5, 0, 0, 0, 0);
    tbl.push_back(f_exp(v, 0, 0, 0, 1, 1, 5, 32'h1234));
    // 4: dependent issues the cycle after
    v = f_iss(z(0), 5, 0, 0, 0, 0, 0);
    tbl.push_back(f_exp(v, 1, 0, 0, 0, 0, 5, 32'h1234));
    // 5: reset mid-flight
    v = f_alu(f_iss(z(1), 0, 0, 0, 0, 0, 0),
          1, 1, 32'h9, 0, 0, 0);
    tbl.push_back(f_exp(v, 0, 0, 0, 0, 0, 5, 32'h1234));
    // 6-8: issue rd=1,2,3
    for (int k = 1; k <= 3; k++) begin
      v = f_iss(z(0), 0, 0, 5'(k), 1, 0, 0);
      tbl.push_back(f_exp(v, 1, 0, 0, 0, 0, 0, 0));
    end
    // 9: tie -> LSU first; 4th issue (no rd)
    v = f_lsu(f_alu(f_iss(z(0), 0, 0, 0, 0, 0, 0),
          1, 1, 32'ha1, 0, 0, 0), 2, 1, 32'hb2);
    tbl.push_back(f_exp(v, 1, 0, 1, 0, 0, 0, 0));
    // 10: tie -> ALU; outstanding full
    v = f_lsu(f_alu(f_iss(z(0), 0, 0, 0, 0, 0, 0),
          1, 1, 32'ha1, 0, 0, 0), 3, 1, 32'hb3);
    tbl.push_back(f_exp(v, 0, 1, 0, 1, 1, 2, 32'hb2));
    // 11: tie -> LSU
    v = f_lsu(f_alu(z(0), 0, 0, 32'hc0, 0, 0, 0),
          3, 1, 32'hb3);
    tbl.push_back(f_exp(v, 0, 0, 1, 1, 1, 1, 32'ha1));
    // 12: ALU alone
    v = f_alu(z(0), 0, 0, 32'hc0, 0, 0, 0);
    tbl.push_back(f_exp(v, 0, 1, 0, 1, 1, 3, 32'hb3));
    // 13: idle
    tbl.push_back(f_exp(z(0), 0, 0, 0, 1, 0, 0, 32'hc0));
    // 14: CSR writer issues
    v = f_iss(z(0), 0, 0, 0, 0, 0, 1);
    tbl.push_back(f_exp(v, 1, 0, 0, 0, 0, 0, 32'hc0));
    // 15: CSR reader stalls; ALU returns mtvec write
    v = f_alu(f_iss(z(0), 0, 0, 4, 1, 1, 0),
          0, 0, 0, 1, 12'h305, 32'h8000_0000);
    tbl.push_back(f_exp(v, 0, 1, 0, 0, 0, 0, 32'hc0));
    // 16: csr_wen1 pulse; reader still stalls
    v = f_iss(z(0), 0, 0, 4, 1, 1, 0);
    v = f_exp(v, 0, 0, 0, 1, 0, 0, 0);
    tbl.push_back(f_csr(v, 1, 12'h305, 32'h8000_0000));
    // 17: reader issues
    v = f_iss(z(0), 0, 0, 4, 1, 1, 0);
    v = f_exp(v, 1, 0, 0, 0, 0, 0, 0);
    tbl.push_back(f_csr(v, 0, 12'h305, 32'h8000_0000));
    // 18: LSU alone (CSR fields must be zeroed)
    v = f_lsu(z(0), 4, 1, 32'h44);
    v = f_exp(v, 0, 0, 1, 0, 0, 0, 0);
    tbl.push_back(f_csr(v, 0, 12'h305, 32'h8000_0000));
    // 19: LSU write_back
    tbl.push_back(f_exp(z(0), 0, 0, 0, 1, 1, 4, 32'h44));
    // 20: issue rd=0 wen
    v = f_iss(z(0), 0, 0, 0, 1, 0, 0);
    tbl.push_back(f_exp(v, 1, 0, 0, 0, 0, 4, 32'h44));
    // 21: rs1=0 never stalls; ALU returns rd=0
    v = f_alu(f_iss(z(0), 0, 0, 0, 0, 0, 0),
          0, 1, 32'h55, 0, 0, 0);
    tbl.push_back(f_exp(v, 1, 1, 0, 0, 0, 4, 32'h44));
    // 22
    v = f_alu(z(0), 0, 0, 32'h66, 0, 0, 0);
    tbl.push_back(f_exp(v, 0, 1, 0, 1, 1, 0, 32'h55));
    // 23
    tbl.push_back(f_exp(z(0), 0, 0, 0, 1, 0, 0, 32'h66));
    // 24: issue rd=3
    v = f_iss(z(0), 0, 0, 3, 1, 0, 0);
    tbl.push_back(f_exp(v, 1, 0, 0, 0, 0, 0, 32'h66));
    // 25: WAW on rd=19 (bit 4 ignored)
    v = f_iss(z(0), 0, 0, 19, 1, 0, 0);
    tbl.push_back(f_exp(v, 0, 0, 0, 0, 0, 0, 32'h66));
    // 26: reset while LSU valid
    v = f_lsu(f_iss(z(1), 3, 0, 0, 0, 0, 0),
          3, 1, 32'h77);
    tbl.push_back(f_exp(v, 0, 0, 0, 0, 0, 0, 32'h66));
    // 27: rs1=19 issues at once
    v = f_iss(z(0), 19, 0, 0, 0, 0, 0);
    tbl.push_back(f_exp(v, 1, 0, 0, 0, 0, 0, 0));

    for (int i = 0; i < tbl.size(); i++) begin
      @(posedge clock);
      #1;
      drv(tbl[i]);
      @(negedge clock);
      chk("iss_ready", i, 32'(iss_ready), 32'(tbl[i].e_ir));
      chk("alu_ready", i, 32'(alu_ready), 32'(tbl[i].e_ar));
      chk("lsu_ready", i, 32'(lsu_ready), 32'(tbl[i].e_lr));
      chk("write_back", i, 32'(write_back), 32'(tbl[i].e_wb));
      chk("wen", i, 32'(wen), 32'(tbl[i].e_wen));
      chk("rd", i, 32'(rd), 32'(tbl[i].e_rd));
      chk("wdata", i, wdata, tbl[i].e_wd);
      chk("csr_wen1", i, 32'(csr_wen1), 32'(tbl[i].e_c1));
      chk("csr_d1", i, 32'(csr_d1), 32'(tbl[i].e_cd));
      chk("csr_wdata1", i, csr_wdata1, tbl[i].e_cwd);
      chk("csr_wen2", i, 32'(csr_wen2), 32'd0);
    end

    // Outstanding limit: four issues fill it, a fifth waits
    // until the cycle after one write_back.
    cyc();
    drv(z(1));
    cyc();
    v = f_iss(z(0), 0, 0, 0, 0, 0, 0);
    drv(v);
    for (int k = 0; k < 4; k++) begin
      @(negedge clock);
      chk("max_fill", k, 32'(iss_ready), 32'd1);
      cyc();
    end
    alu_valid = 1'b1;
    alu_wdata = 32'h5a5a;
    @(negedge clock);
    chk("max_full", 0, 32'(iss_ready), 32'd0);
    chk("max_grant", 0, 32'(alu_ready), 32'd1);
    cyc();
    alu_valid = 1'b0;
    @(negedge clock);
    chk("max_wb", 0, 32'(write_back), 32'd1);
    chk("max_wdata", 0, wdata, 32'h5a5a);
    chk("max_wb_stall", 0, 32'(iss_ready), 32'd0);
    cyc();
    @(negedge clock);
    chk("max_release", 0, 32'(iss_ready), 32'd1);
    cyc();
    drv(z(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
